// File: rtl/adc_peak_quantizer_if.sv
// AXI-Stream bundle for adc_peak_quantizer.
// It carries the ADC beat from the RFdc, which is the s_axis side, and its
// DMA mirror toward the PS, which is the m_axis side.
//   slave  : the quantizer's view (consumes s_axis, produces m_axis)
//   master : the environment's view (produces s_axis, consumes m_axis)
interface adc_peak_quantizer_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/adc_peak_quantizer.sv
// ADC peak quantizer.
// The block finds the signed max or min over LANES samples per beat across
// a window of WIN beats. It then maps that peak to a level index with a
// pipelined binary search over an ascending threshold table. Raw beats can
// be mirrored to DMA.
//   clk          : single clock
//   rst_n        : asynchronous reset, active low
//   gpio_i       : [15:0] address, [23:16] data, [24] write strobe (async)
//   run_i        : window enable from the experiment FSM
//   axis         : s_axis ADC beat in / m_axis DMA copy out
//   val_out_o    : quantized level index, held between results
//   val_valid_o  : one-cycle pulse when val_out_o is updated
module adc_peak_quantizer #(
  parameter int SAMPLE_W  = 8,
  parameter int LANES     = 16,
  parameter int LUT_DEPTH = 256,
  parameter int GPIO_BASE = 0,
  localparam int LOG2     = $clog2(LUT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         gpio_i,
  input  logic                run_i,
  adc_peak_quantizer_if.slave axis,
  output logic [LOG2-1:0]     val_out_o,
  output logic                val_valid_o
);

  localparam logic [15:0] ADDR_LO  = 16'(GPIO_BASE + 1);
  localparam logic [15:0] ADDR_HI  = 16'(GPIO_BASE + LUT_DEPTH - 1);
  localparam logic [15:0] ADDR_WIN = 16'(GPIO_BASE + LUT_DEPTH);
  localparam logic [15:0] ADDR_CTL = 16'(GPIO_BASE + LUT_DEPTH + 1);
  localparam logic signed [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // ---------------- GPIO register file ----------------
  logic [1:0] wsync_q;
  logic       wprev_q;
  logic       gpio_we;
  logic [15:0] gpio_addr;
  logic [7:0]  gpio_data;
  logic [LOG2-1:0] tbl_idx;
  logic unused_gpio;

  logic signed [SAMPLE_W-1:0] thr_q [LUT_DEPTH];
  logic [7:0] win_q;
  logic       mode_q;
  logic       dma_en_q;

  assign gpio_addr   = gpio_i[15:0];
  assign gpio_data   = gpio_i[23:16];
  assign gpio_we     = wsync_q[1] & ~wprev_q;
  assign tbl_idx     = LOG2'(gpio_addr - 16'(GPIO_BASE));
  assign unused_gpio = ^gpio_i[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsync_q  <= '0;
      wprev_q  <= 1'b0;
      win_q    <= 8'd1;
      mode_q   <= 1'b0;
      dma_en_q <= 1'b0;
      // Uniform spread over the signed sample range; entry 0 is never probed.
      for (int k = 0; k < LUT_DEPTH; k++) begin
        thr_q[k] <= SAMPLE_W'((k * (1 << SAMPLE_W)) / LUT_DEPTH - (1 << (SAMPLE_W - 1)));
      end
    end else begin
      wsync_q <= {wsync_q[0], gpio_i[24]};
      wprev_q <= wsync_q[1];
      if (gpio_we) begin
        if (gpio_addr >= ADDR_LO && gpio_addr <= ADDR_HI) begin
          thr_q[tbl_idx] <= gpio_data[SAMPLE_W-1:0];
        end else if (gpio_addr == ADDR_WIN) begin
          win_q <= (gpio_data == 8'd0) ? 8'd1 : gpio_data;
        end else if (gpio_addr == ADDR_CTL) begin
          mode_q   <= gpio_data[0];
          dma_en_q <= gpio_data[1];
        end
      end
    end
  end

  // ---------------- AXIS passthrough ----------------
  logic accept;

  assign axis.s_axis_tready = ~dma_en_q | axis.m_axis_tready;
  assign axis.m_axis_tdata  = axis.s_axis_tdata;
  assign axis.m_axis_tvalid = axis.s_axis_tvalid & dma_en_q;
  assign accept             = axis.s_axis_tvalid & axis.s_axis_tready;

  // ---------------- Windowing ----------------
  // rem_q is a down-counter of beats still owed to the open window.
  // act_q marks a window that is open. A window opens on its first beat,
  // and mode is latched there so mid-window writes wait for the next window.
  logic       act_q, act_d;
  logic [7:0] rem_q, rem_d;
  logic       win_mode_q, win_mode_d;
  logic signed [SAMPLE_W-1:0] peak_q, peak_d;
  logic signed [SAMPLE_W-1:0] lane_s, beat_pk, new_pk;
  logic cur_mode;
  logic launch;

  assign cur_mode = act_q ? win_mode_q : mode_q;

  always_comb begin
    lane_s  = '0;
    beat_pk = $signed(axis.s_axis_tdata[SAMPLE_W-1:0]);
    for (int l = 1; l < LANES; l++) begin
      lane_s = $signed(axis.s_axis_tdata[l*SAMPLE_W +: SAMPLE_W]);
      if (cur_mode ? (lane_s < beat_pk) : (lane_s > beat_pk)) begin
        beat_pk = lane_s;
      end
    end
    new_pk = beat_pk;
    if (act_q && (cur_mode ? (peak_q < beat_pk) : (peak_q > beat_pk))) begin
      new_pk = peak_q;
    end
  end

  always_comb begin
    launch     = 1'b0;
    act_d      = act_q;
    rem_d      = rem_q;
    peak_d     = peak_q;
    win_mode_d = win_mode_q;
    if (!run_i) begin
      act_d  = 1'b0;
      rem_d  = '0;
      peak_d = MOST_NEG;
    end else if (accept) begin
      if (!act_q) begin
        win_mode_d = mode_q;
      end
      if ((act_q && rem_q == 8'd1) || (!act_q && win_q == 8'd1)) begin
        launch = 1'b1;
        act_d  = 1'b0;
        rem_d  = '0;
        peak_d = MOST_NEG;
      end else begin
        act_d  = 1'b1;
        rem_d  = act_q ? (rem_q - 8'd1) : (win_q - 8'd1);
        peak_d = new_pk;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      rem_q      <= '0;
      peak_q     <= MOST_NEG;
      win_mode_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      rem_q      <= rem_d;
      peak_q     <= peak_d;
      win_mode_q <= win_mode_d;
    end
  end

  // ---------------- Binary-search quantizer ----------------
  // Slot 0 holds the launched peak. Stage s probes bit LOG2-1-s of the index.
  // An extra output register follows the last stage.
  logic signed [SAMPLE_W-1:0] pk_q [LOG2];
  logic [LOG2-1:0] idx_q [LOG2+1];
  logic [LOG2:0]   vld_q;
  logic [LOG2-1:0] cand_d [LOG2];
  logic [LOG2-1:0] idx_d [LOG2];
  logic [LOG2-1:0] val_out_q;
  logic            val_valid_q;

  always_comb begin
    for (int s = 0; s < LOG2; s++) begin
      cand_d[s] = idx_q[s] | (LOG2'(1) << (LOG2 - 1 - s));
      idx_d[s]  = (pk_q[s] >= thr_q[cand_d[s]]) ? cand_d[s] : idx_q[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      val_out_q   <= '0;
      val_valid_q <= 1'b0;
      for (int s = 0; s < LOG2; s++) begin
        pk_q[s] <= MOST_NEG;
      end
      for (int s = 0; s <= LOG2; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= launch;
      pk_q[0]  <= new_pk;
      idx_q[0] <= '0;
      for (int s = 0; s < LOG2; s++) begin
        vld_q[s+1] <= vld_q[s];
        idx_q[s+1] <= idx_d[s];
        if (s < LOG2 - 1) begin
          pk_q[s+1] <= pk_q[s];
        end
      end
      val_valid_q <= vld_q[LOG2];
      if (vld_q[LOG2]) begin
        val_out_q <= idx_q[LOG2];
      end
    end
  end

  assign val_out_o   = val_out_q;
  assign val_valid_o = val_valid_q;

endmodule
